shift_word_collector: RTL and testbench
=======================================

# shift_word_collector

Serial-to-parallel receiver that sits at the far end of the universal shift register's serial outputs. It samples one bit per qualified clock from `s_right_dout` (LSB-first stream) or `s_left_dout` (MSB-first stream) and reassembles `WIDTH`-bit words. Each completed word is presented on a single-entry output register with a valid/ready handshake. Overrun is flagged when a word completes while the output register is still occupied.

## Interface
- `WIDTH`, 4: word width in bits; legal range 2–32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_din`  in  1  serial data bit.
- `s_valid`  in  1  `s_din` is sampled on this edge.
- `s_dir`  in  1  bit order: 0 = LSB first (right-shift stream), 1 = MSB first (left-shift stream); latched on the first bit of each word.
- `s_sync`  in  1  discards any partial word and realigns the bit counter to 0.
- `p_ready`  in  1  consumer accepts `p_dout`.
- `clr_ovr`  in  1  clears the sticky `overrun` flag.
- `p_dout`  out  WIDTH  assembled word.
- `p_valid`  out  1  `p_dout` holds an unconsumed word.
- `par_err`  out  1  parity error attached to the word in `p_dout`.
- `overrun`  out  1  sticky flag: a completed word was dropped.
- `busy`  out  1  partial word in progress (bit count ≠ 0).

## Operation
- Reset values: `p_dout`=0, `p_valid`=0, `par_err`=0, `overrun`=0, `busy`=0. The internal shift register, bit counter, latched direction and FSM are also cleared. Reset mid-word discards the partial word.
- FSM states:
  - IDLE → COLLECT on `s_valid`. That first bit is captured and `s_dir` is latched.
  - COLLECT → IDLE after bit `WIDTH` is captured (macro off), or → PARITY (macro on).
  - PARITY → IDLE on the next `s_valid`.
- Assembly:
  - LSB first: `sh <= {s_din, sh[WIDTH-1:1]}`. The first bit ends up in bit 0.
  - MSB first: `sh <= {sh[WIDTH-2:0], s_din}`. The first bit ends up in bit `WIDTH-1`.
- `s_dir` changes during a word are ignored.
- Word completion:
  - If `p_valid`=0, or `p_valid`=1 and `p_ready`=1 in the same cycle, the word loads into `p_dout` and `p_valid`=1.
  - Otherwise the new word is dropped, `p_dout` is unchanged, and `overrun` is set.
- Handshake:
  - Transfer occurs on any edge with `p_valid`=1 and `p_ready`=1. `p_valid` then falls unless a new word loads on the same edge.
  - `p_dout` is stable while `p_valid`=1 and `p_ready`=0.
- `s_sync` priority: `s_sync` beats an in-progress word. With `s_sync`=1 and `s_valid`=1 together, the partial word is discarded and the current bit becomes bit 1 of a new word. `s_sync` never affects `p_dout`, `p_valid` or `overrun`.
- `clr_ovr` vs. overrun: if `clr_ovr` and a new overrun event occur in the same cycle, set wins and `overrun`=1.
- `s_valid`=0 cycles stall assembly indefinitely. No timeout.

## Timing
- `p_valid` rises on the clock edge that samples the final bit of a word (data bit `WIDTH`, or the parity bit with the macro on). It is visible the cycle after the final bit is presented.
- Back-to-back words are supported at full rate (one bit per cycle, no gap), provided the consumer holds `p_ready`=1.
- `busy` is registered. It is 1 from the edge sampling bit 1 through the edge before completion, and 0 on the completing edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SHIFT_COLLECT_PARITY_EN`:
  - Defined: every word is followed by one even-parity bit, and the FSM uses the PARITY state. On completion, `par_err` loads `^{data, parity_bit}`. `par_err` travels with `p_dout` and is overwritten only when a new word loads.
  - Undefined: there is no PARITY state and a word completes after `WIDTH` bits. `par_err` is tied to 0.

## Test plan
- LSB first, `WIDTH`=4, `s_dir`=0, bits 1,0,1,1 on consecutive cycles with `p_ready`=1 → `p_dout`=4'b1101 and `p_valid`=1 for one cycle, starting the edge after the 4th bit.
- MSB first, `s_dir`=1, bits 1,1,0,1 → `p_dout`=4'b1101. Toggling `s_dir` after bit 1 has no effect.
- Backpressure: `p_ready`=0, send word 4'b1101 then word 4'b0110 → `p_dout` stays 4'b1101 and `overrun`=1 after the 8th bit. `clr_ovr` then clears it. Raising `p_ready` gives one transfer and `p_valid`=0.
- Sync: send 2 bits, pulse `s_sync` with `s_valid`=1 on bit 1, then 3 more bits (pattern 0011 LSB first) → `p_dout`=4'b1100. No stray word is emitted.
- Reset mid-word: 2 bits in, assert `rst_n`=0 asynchronously between edges → all outputs 0 immediately. The next 4 bits form a clean word.
- Macro on: 4'b1101 plus parity bit 1 → `par_err`=0. The same word with parity bit 0 → `par_err`=1. `p_valid` rises only after the 5th bit.

Source files
------------

// File: rtl/shift_word_collector.sv
// ---------------------------------------------------------------------------
// shift_word_collector
//
// Serial-to-parallel receiver for the serial outputs of a universal shift
// register. One bit is taken per clock with s_valid asserted. The stream is
// either LSB first (s_dir=0) or MSB first (s_dir=1). The order is latched on
// the first bit of each word. Completed WIDTH-bit words are handed to a
// single-entry output register that has a valid/ready handshake.
//
// Optional feature macro: SHIFT_COLLECT_PARITY_EN
//   When defined, each word is followed by one even-parity bit. par_err
//   reports a parity mismatch for the word held in p_dout.
//   When undefined, a word completes after WIDTH bits and par_err is 0.
//
// Parameters
//   WIDTH    word width in bits, 2..32
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   s_din    serial data bit
//   s_valid  s_din is sampled on this edge
//   s_dir    bit order, 0 = LSB first, 1 = MSB first (latched on bit 1)
//   s_sync   drop any partial word; the current bit (if valid) starts a new one
//   p_ready  consumer accepts p_dout
//   clr_ovr  clears the sticky overrun flag
//   p_dout   assembled word
//   p_valid  p_dout holds an unconsumed word
//   par_err  parity error for the word in p_dout
//   overrun  sticky: a completed word was dropped
//   busy     partial word in progress
// ---------------------------------------------------------------------------
module shift_word_collector #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_din,
    input  logic             s_valid,
    input  logic             s_dir,
    input  logic             s_sync,
    input  logic             p_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    output logic             par_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
`ifdef SHIFT_COLLECT_PARITY_EN
    localparam logic [1:0] ST_PARITY  = 2'd2;
`endif

    // The counter holds the number of data bits already captured. A word
    // finishes its data phase when the bit arrives while the counter is WIDTH-1.
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [1:0]       state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] sh_q,      sh_d;
    logic             dir_q,     dir_d;
    logic [WIDTH-1:0] p_dout_q,  p_dout_d;
    logic             p_valid_q, p_valid_d;
    logic             overrun_q, overrun_d;
    logic             busy_q,    busy_d;
`ifdef SHIFT_COLLECT_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    logic             start;
    logic             eff_dir;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             parity_bad;

    always_comb begin
        // NOTE: every variable gets a default first so that no path leaves one
        // unassigned. A path that skipped an assignment would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        dir_d      = dir_q;
        p_dout_d   = p_dout_q;
        p_valid_d  = p_valid_q;
        overrun_d  = overrun_q;
        word_done  = 1'b0;
        word       = sh_q;
        parity_bad = 1'b0;
`ifdef SHIFT_COLLECT_PARITY_EN
        par_err_d  = par_err_q;
`endif

        // A new word starts on any valid bit from IDLE. It also starts on a
        // valid bit with s_sync, which throws away whatever was partly built.
        start   = s_valid && (s_sync || (state_q == ST_IDLE));
        eff_dir = start ? s_dir : dir_q;
        base    = start ? '0 : sh_q;
        shifted = eff_dir ? {base[WIDTH-2:0], s_din}
                          : {s_din, base[WIDTH-1:1]};

        if (s_sync && !s_valid) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sh_d    = '0;
        end else if (s_valid) begin
            if (start) begin
                sh_d    = shifted;
                dir_d   = s_dir;
                cnt_d   = CW'(1);
                state_d = ST_COLLECT;
            end else if (state_q == ST_COLLECT) begin
                sh_d = shifted;
                if (cnt_q == LAST_IDX) begin
`ifdef SHIFT_COLLECT_PARITY_EN
                    state_d = ST_PARITY;
                    cnt_d   = cnt_q + CW'(1);
`else
                    word_done = 1'b1;
                    word      = shifted;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`ifdef SHIFT_COLLECT_PARITY_EN
            end else if (state_q == ST_PARITY) begin
                // This bit is the even-parity bit. The data sits unchanged in sh_q.
                word_done  = 1'b1;
                word       = sh_q;
                parity_bad = ^{sh_q, s_din};
                state_d    = ST_IDLE;
                cnt_d      = '0;
`endif
            end
        end

        // Output register: drain first, then load. A load on the same edge
        // as a transfer keeps p_valid high.
        if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (word_done) begin
            if (!p_valid_q || p_ready) begin
                p_dout_d  = word;
                p_valid_d = 1'b1;
`ifdef SHIFT_COLLECT_PARITY_EN
                par_err_d = parity_bad;
`endif
            end else begin
                // The word is dropped. Setting the flag wins over clr_ovr.
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together from values computed before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            dir_q     <= 1'b0;
            p_dout_q  <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            dir_q     <= dir_d;
            p_dout_q  <= p_dout_d;
            p_valid_q <= p_valid_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

`ifdef SHIFT_COLLECT_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign p_dout  = p_dout_q;
    assign p_valid = p_valid_q;
    assign overrun = overrun_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_shift_word_collector.sv
// ---------------------------------------------------------------------------
// tb_shift_word_collector
//
// Directed bench for shift_word_collector with WIDTH=4. Each stimulus step is
// followed by comparisons against hand-computed expected values. Outputs are
// sampled 1 ns after the rising edge. With SHIFT_COLLECT_PARITY_EN defined, the
// helper tasks append the even-parity bit, and an extra parity section runs.
// ---------------------------------------------------------------------------
module tb_shift_word_collector;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             s_din;
    logic             s_valid;
    logic             s_dir;
    logic             s_sync;
    logic             p_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] p_dout;
    logic             p_valid;
    logic             par_err;
    logic             overrun;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    shift_word_collector #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_din   (s_din),
        .s_valid (s_valid),
        .s_dir   (s_dir),
        .s_sync  (s_sync),
        .p_ready (p_ready),
        .clr_ovr (clr_ovr),
        .p_dout  (p_dout),
        .p_valid (p_valid),
        .par_err (par_err),
        .overrun (overrun),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one serial bit for exactly one edge.
    task automatic bit_in(input logic b, input logic dir);
        s_din   = b;
        s_dir   = dir;
        s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
    endtask

    // Send a whole word back-to-back. seq[3] is the first bit on the wire.
    // With rdy_last set, p_ready rises just before the final bit.
    task automatic send4(input logic [3:0] seq, input logic dir, input logic rdy_last);
        for (int i = 3; i >= 0; i--) begin
`ifndef SHIFT_COLLECT_PARITY_EN
            if (rdy_last && i == 0) p_ready = 1'b1;
`endif
            bit_in(seq[i], dir);
        end
`ifdef SHIFT_COLLECT_PARITY_EN
        if (rdy_last) p_ready = 1'b1;
        bit_in(^seq, dir);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        s_din   = 1'b0;
        s_valid = 1'b0;
        s_dir   = 1'b0;
        s_sync  = 1'b0;
        p_ready = 1'b0;
        clr_ovr = 1'b0;

        // Reset state
        #12;
        check("rst_p_dout",  32'(p_dout),  32'h0);
        check("rst_p_valid", 32'(p_valid), 32'h0);
        check("rst_par_err", 32'(par_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // LSB first: bits 1,0,1,1 -> 1101, valid for one cycle
        p_ready = 1'b1;
        send4(4'b1011, 1'b0, 1'b0);
        check("lsb_p_valid", 32'(p_valid), 32'h1);
        check("lsb_p_dout",  32'(p_dout),  32'hD);
        check("lsb_busy",    32'(busy),    32'h0);
        cycle();
        check("lsb_drained", 32'(p_valid), 32'h0);

        // MSB first: bits 1,1,0,1; s_dir flips after bit 1 and must be ignored
        bit_in(1'b1, 1'b1);
        check("msb_busy_b1", 32'(busy), 32'h1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
`ifdef SHIFT_COLLECT_PARITY_EN
        bit_in(1'b1, 1'b0);
`endif
        check("msb_p_valid", 32'(p_valid), 32'h1);
        check("msb_p_dout",  32'(p_dout),  32'hD);
        cycle();
        check("msb_drained", 32'(p_valid), 32'h0);

        // Full-rate back-to-back words with the consumer always ready
        send4(4'b1011, 1'b0, 1'b0);
        check("b2b_w1_dout", 32'(p_dout), 32'hD);
        send4(4'b0110, 1'b0, 1'b0);
        check("b2b_w2_dout",  32'(p_dout),  32'h6);
        check("b2b_w2_valid", 32'(p_valid), 32'h1);
        check("b2b_overrun",  32'(overrun), 32'h0);
        cycle();

        // Backpressure: the second word is dropped and overrun is set
        p_ready = 1'b0;
        send4(4'b1011, 1'b0, 1'b0);
        send4(4'b0110, 1'b0, 1'b0);
        check("bp_p_dout",  32'(p_dout),  32'hD);
        check("bp_p_valid", 32'(p_valid), 32'h1);
        check("bp_overrun", 32'(overrun), 32'h1);
        clr_ovr = 1'b1;
        cycle();
        clr_ovr = 1'b0;
        check("bp_clr_ovr",   32'(overrun), 32'h0);
        check("bp_held",      32'(p_valid), 32'h1);
        p_ready = 1'b1;
        cycle();
        p_ready = 1'b0;
        check("bp_xfer_valid", 32'(p_valid), 32'h0);
        check("bp_xfer_dout",  32'(p_dout),  32'hD);

        // When clr_ovr coincides with a new overrun, the set wins
        send4(4'b0001, 1'b0, 1'b0);
        check("sw_p_dout", 32'(p_dout), 32'h8);
        clr_ovr = 1'b1;
        send4(4'b1111, 1'b0, 1'b0);
        check("sw_overrun", 32'(overrun), 32'h1);
        check("sw_p_dout2", 32'(p_dout),  32'h8);
        cycle();
        clr_ovr = 1'b0;
        check("sw_cleared", 32'(overrun), 32'h0);

        // Transfer and load on the same edge keep p_valid high
        send4(4'b0110, 1'b0, 1'b1);
        check("xl_p_valid", 32'(p_valid), 32'h1);
        check("xl_p_dout",  32'(p_dout),  32'h6);
        check("xl_overrun", 32'(overrun), 32'h0);
        cycle();
        check("xl_drained", 32'(p_valid), 32'h0);

        // Sync: 2 stray bits, then s_sync with the first bit of 0,0,1,1 -> 1100
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        check("sync_busy_pre", 32'(busy), 32'h1);
        s_sync = 1'b1;
        bit_in(1'b0, 1'b0);
        s_sync = 1'b0;
        check("sync_busy_b1", 32'(busy), 32'h1);
        bit_in(1'b0, 1'b0);
        check("sync_no_stray", 32'(p_valid), 32'h0);
        bit_in(1'b1, 1'b0);
        check("sync_no_early", 32'(p_valid), 32'h0);
        bit_in(1'b1, 1'b0);
`ifdef SHIFT_COLLECT_PARITY_EN
        bit_in(1'b0, 1'b0);
`endif
        check("sync_p_valid", 32'(p_valid), 32'h1);
        check("sync_p_dout",  32'(p_dout),  32'hC);
        check("sync_busy",    32'(busy),    32'h0);
        cycle();

        // Asynchronous reset in the middle of a word, with a full output register and overrun set
        p_ready = 1'b0;
        send4(4'b1011, 1'b0, 1'b0);
        send4(4'b0110, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        check("ar_pre_busy",    32'(busy),    32'h1);
        check("ar_pre_overrun", 32'(overrun), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_p_dout",  32'(p_dout),  32'h0);
        check("ar_p_valid", 32'(p_valid), 32'h0);
        check("ar_overrun", 32'(overrun), 32'h0);
        check("ar_busy",    32'(busy),    32'h0);
        check("ar_par_err", 32'(par_err), 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        p_ready = 1'b1;
        send4(4'b0110, 1'b0, 1'b0);
        check("ar_clean_valid", 32'(p_valid), 32'h1);
        check("ar_clean_dout",  32'(p_dout),  32'h6);
        cycle();

`ifdef SHIFT_COLLECT_PARITY_EN
        // Parity: 1101 with even-parity bit 1 is good; with bit 0 it is bad
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        check("par_wait_valid", 32'(p_valid), 32'h0);
        check("par_wait_busy",  32'(busy),    32'h1);
        bit_in(1'b1, 1'b0);
        check("par_ok_valid", 32'(p_valid), 32'h1);
        check("par_ok_dout",  32'(p_dout),  32'hD);
        check("par_ok_err",   32'(par_err), 32'h0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        check("par_bad_err",  32'(par_err), 32'h1);
        check("par_bad_dout", 32'(p_dout),  32'hD);
        cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
